vga_bounce_overlay: RTL and testbench

- Pixel-path stage directly downstream of the 1280x1024 timing/colour-bar generator.
- Consumes its horizontal/vertical counters, sync outputs and bar RGB.
- Overlays a solid rectangle that bounces off the active-area edges, moving once per frame.
- Emits re-aligned sync and RGB to the VGA pins, with a fixed 2-cycle latency on every output.

---
 rtl/vga_pkg.sv | 49 ++++
 rtl/vga_bounce_overlay_if.sv | 24 ++
 rtl/vga_bounce_overlay_axis.sv | 58 +++++
 rtl/vga_bounce_overlay.sv | 114 +++++++++++
 tb/tb_vga_bounce_overlay.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared 1280x1024 VGA timing constants and pixel-path types.
// Colour words are packed {r,g,b}, 4 bits each.
package vga_pkg;

  localparam int HPIXELS = 1688;
  localparam int VLINES  = 1066;
  localparam int HPULSE  = 112;
  localparam int VPULSE  = 3;
  localparam int HBP     = 360;
  localparam int HFP     = 1640;
  localparam int VBP     = 35;
  localparam int VFP     = 1059;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  typedef struct packed {
    logic hs;
    logic vs;
    rgb_t rgb;
    logic act;
    logic box;
    logic tick;
  } s1_t;

  typedef struct packed {
    logic hs;
    logic vs;
    rgb_t rgb;
  } s2_t;

  localparam s1_t S1_RST = '{
    hs: 1'b1, vs: 1'b1, rgb: '0,
    act: 1'b0, box: 1'b0, tick: 1'b0
  };

  localparam s2_t S2_RST = '{
    hs: 1'b1, vs: 1'b1, rgb: '0
  };

endpackage

// File: rtl/vga_bounce_overlay_if.sv
// VGA pixel bus: raster counters, syncs and rgb444 colour.
// The same bundle describes the upstream feed and the pin side.
interface vga_bounce_overlay_if;
  import vga_pkg::*;

  logic [10:0] hc;
  logic [10:0] vc;
  logic        hsync;
  logic        vsync;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;

  modport master (
    output hc, vc, hsync, vsync,
    output red, green, blue
  );

  modport slave (
    input hc, vc, hsync, vsync,
    input red, green, blue
  );

endinterface

// File: rtl/vga_bounce_overlay_axis.sv
// One bouncing axis: position walks by STEP per advance and
// reverses at 0 and MAX, clamping to the wall on the hit frame.
module bounce_axis
  import vga_pkg::*;
#(
  parameter int STEP = 4,
  parameter int MAX  = 1216
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  output logic [11:0] pos
);

  localparam logic [11:0] STP = 12'(STEP);
  localparam logic [11:0] LIM = 12'(MAX);

  logic [11:0] pos_d, pos_q;
  dir_e        dir_d, dir_q;

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (adv) begin
      unique case (dir_q)
        DIR_INC: begin
          if (pos_q + STP >= LIM) begin
            pos_d = LIM;
            dir_d = DIR_DEC;
          end else begin
            pos_d = pos_q + STP;
          end
        end
        DIR_DEC: begin
          if (pos_q <= STP) begin
            pos_d = '0;
            dir_d = DIR_INC;
          end else begin
            pos_d = pos_q - STP;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
      dir_q <= DIR_INC;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/vga_bounce_overlay.sv
// Two-stage pixel path overlaying a bouncing box on the bar feed;
// every pin output lags its input by two dclk cycles.
module vga_bounce_overlay
  import vga_pkg::*;
#(
  parameter int          ACT_W   = 1280,
  parameter int          ACT_H   = 1024,
  parameter int          BOX_W   = 64,
  parameter int          BOX_H   = 48,
  parameter int          STEP_X  = 4,
  parameter int          STEP_Y  = 3,
  parameter logic [11:0] BOX_RGB = 12'hF80
) (
  input  logic        dclk,
  input  logic        clr_n,
  input  logic [10:0] hc,
  input  logic [10:0] vc,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [3:0]  red_in,
  input  logic [3:0]  green_in,
  input  logic [3:0]  blue_in,
  input  logic        en,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frame_tick
);

  localparam logic [11:0] H0 = 12'(HBP);
  localparam logic [11:0] H1 = 12'(HBP + ACT_W);
  localparam logic [11:0] V0 = 12'(VBP);
  localparam logic [11:0] V1 = 12'(VBP + ACT_H);
  localparam logic [11:0] BW = 12'(BOX_W);
  localparam logic [11:0] BH = 12'(BOX_H);
  localparam logic [10:0] TICK_V = 11'(VBP + ACT_H);

  logic [11:0] x_pos, y_pos;
  logic [11:0] h12, v12, hrel, vrel;
  logic        act, adv;
  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;

  always_comb begin
    h12  = {1'b0, hc};
    v12  = {1'b0, vc};
    hrel = h12 - H0;
    vrel = v12 - V0;
    act  = (h12 >= H0) && (h12 < H1) &&
           (v12 >= V0) && (v12 < V1);
    s1_d.hs   = hsync_in;
    s1_d.vs   = vsync_in;
    s1_d.rgb  = '{r: red_in, g: green_in, b: blue_in};
    s1_d.act  = act;
    s1_d.box  = act &&
                (hrel >= x_pos) && (hrel < x_pos + BW) &&
                (vrel >= y_pos) && (vrel < y_pos + BH);
    s1_d.tick = (hc == 11'd0) && (vc == TICK_V);
  end

  always_comb begin
    s2_d.hs  = s1_q.hs;
    s2_d.vs  = s1_q.vs;
    s2_d.rgb = '0;
    if (s1_q.box && en) begin
      s2_d.rgb = rgb_t'(BOX_RGB);
    end else if (s1_q.act) begin
      s2_d.rgb = s1_q.rgb;
    end
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      s1_q <= S1_RST;
      s2_q <= S2_RST;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // The tick sits on the first blanking line, so moves never tear.
  assign adv = s1_q.tick & en;

  bounce_axis #(
    .STEP (STEP_X),
    .MAX  (ACT_W - BOX_W)
  ) u_axis_x (
    .clk   (dclk),
    .rst_n (clr_n),
    .adv   (adv),
    .pos   (x_pos)
  );

  bounce_axis #(
    .STEP (STEP_Y),
    .MAX  (ACT_H - BOX_H)
  ) u_axis_y (
    .clk   (dclk),
    .rst_n (clr_n),
    .adv   (adv),
    .pos   (y_pos)
  );

  assign hsync      = s2_q.hs;
  assign vsync      = s2_q.vs;
  assign red        = s2_q.rgb.r;
  assign green      = s2_q.rgb.g;
  assign blue       = s2_q.rgb.b;
  assign frame_tick = s1_q.tick;

endmodule

// File: tb/tb_vga_bounce_overlay.sv
// Self-checking bench for vga_bounce_overlay: vector table,
// frame-walk corner sequences and randomized pixels vs a model.
module tb_vga_bounce_overlay;
  import vga_pkg::*;

  localparam int XMAX = 1216;
  localparam int YMAX = 976;
  localparam int SX   = 4;
  localparam int SY   = 3;
  localparam logic [11:0] BOXC = 12'hF80;
  localparam logic [11:0] BAR  = 12'h3C7;

  logic dclk = 1'b0;
  logic clr_n = 1'b0;
  logic en = 1'b0;
  logic frame_tick;

  vga_bounce_overlay_if up ();
  vga_bounce_overlay_if dn ();

  always #5 dclk = ~dclk;

  vga_bounce_overlay dut (
    .dclk       (dclk),
    .clr_n      (clr_n),
    .hc         (up.hc),
    .vc         (up.vc),
    .hsync_in   (up.hsync),
    .vsync_in   (up.vsync),
    .red_in     (up.red),
    .green_in   (up.green),
    .blue_in    (up.blue),
    .en         (en),
    .hsync      (dn.hsync),
    .vsync      (dn.vsync),
    .red        (dn.red),
    .green      (dn.green),
    .blue       (dn.blue),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  typedef struct {
    int          h;
    int          v;
    logic [11:0] rgb;
    logic [11:0] exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   ticks  = 0;
  int   mx, my, vx, vy;
  exp_t prev;
  vec_t tbl [11];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t",
               nm, got, want, $time);
    end
  endtask

  function automatic logic [11:0] ref_px(input int h, input int v,
                                         input logic [11:0] c,
                                         input logic e);
    bit a, b;
    a = h >= HBP && h < HBP + 1280 && v >= VBP && v < VBP + 1024;
    b = a && (h - HBP) >= mx && (h - HBP) < mx + 64 &&
         (v - VBP) >= my && (v - VBP) < my + 48;
    if (b && e) return BOXC;
    if (a) return c;
    return 12'h000;
  endfunction

  function automatic void ref_axis(inout int p, inout int d,
                                   input int lim);
    if (d > 0) begin
      if (p + d >= lim) begin p = lim; d = -d; end
      else p = p + d;
    end else begin
      if (p <= -d) begin p = 0; d = -d; end
      else p = p + d;
    end
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; vx = SX; vy = SY;
    prev = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};
  endtask

  task automatic step(input int h, input int v,
                      input logic hs, input logic vs,
                      input logic [11:0] c);
    exp_t e;
    e.hs  = hs;
    e.vs  = vs;
    e.rgb = ref_px(h, v, c, en);
    up.hc    = 11'(h);
    up.vc    = 11'(v);
    up.hsync = hs;
    up.vsync = vs;
    up.red   = c[11:8];
    up.green = c[7:4];
    up.blue  = c[3:0];
    @(posedge dclk);
    #1;
    chk("hsync", dn.hsync, prev.hs);
    chk("vsync", dn.vsync, prev.vs);
    chk("rgb", {dn.red, dn.green, dn.blue}, prev.rgb);
    chk("tick", frame_tick, (h == 0 && v == 1059));
    if (frame_tick === 1'b1) ticks++;
    prev = e;
  endtask

  task automatic blank();
    step(0, 0, 1'b1, 1'b1, 12'h5A5);
  endtask

  task automatic next_frame();
    step(0, 1059, 1'b1, 1'b0, 12'(($urandom)));
    blank();
    if (en) begin
      ref_axis(mx, vx, XMAX);
      ref_axis(my, vy, YMAX);
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) next_frame();
  endtask

  task automatic set_en(input logic v);
    blank();
    en = v;
    blank();
  endtask

  task automatic probe(input string nm, input int hr, input int vr,
                       input bit box);
    step(HBP + hr, VBP + vr, 1'b0, 1'b1, BAR);
    blank();
    chk(nm, {dn.red, dn.green, dn.blue}, box ? BOXC : BAR);
  endtask

  initial begin
    tbl[0]  = '{360,  35,   BAR, BOXC};
    tbl[1]  = '{424,  35,   BAR, BAR};
    tbl[2]  = '{423,  82,   BAR, BOXC};
    tbl[3]  = '{423,  83,   BAR, BAR};
    tbl[4]  = '{359,  35,   BAR, 12'h000};
    tbl[5]  = '{360,  34,   BAR, 12'h000};
    tbl[6]  = '{1640, 40,   BAR, 12'h000};
    tbl[7]  = '{2000, 35,   BAR, 12'h000};
    tbl[8]  = '{360,  1059, BAR, 12'h000};
    tbl[9]  = '{1639, 1058, BAR, BAR};
    tbl[10] = '{400,  60,   12'h123, BOXC};

    up.hc = '0; up.vc = '0;
    up.hsync = 1'b1; up.vsync = 1'b1;
    up.red = '0; up.green = '0; up.blue = '0;
    model_reset();
    en = 1'b1;
    repeat (3) @(posedge dclk);
    #1;
    chk("rst_hsync", dn.hsync, 1'b1);
    chk("rst_vsync", dn.vsync, 1'b1);
    chk("rst_rgb", {dn.red, dn.green, dn.blue}, 12'h000);
    chk("rst_tick", frame_tick, 1'b0);
    clr_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].h, tbl[i].v, 1'b0, 1'b0, tbl[i].rgb);
      blank();
      chk($sformatf("tbl%0d", i),
          {dn.red, dn.green, dn.blue}, tbl[i].exp);
    end

    ticks = 0;
    frames(10);
    chk("ticks10", ticks, 10);
    probe("x40y30", 40, 30, 1'b1);
    probe("x39y30", 39, 30, 1'b0);
    probe("x40y29", 40, 29, 1'b0);

    frames(294);
    probe("xmax", 1216, 912, 1'b1);
    probe("xmax_l", 1215, 912, 1'b0);
    probe("xmax_br", 1279, 959, 1'b1);
    frames(1);
    probe("xback", 1212, 915, 1'b1);
    probe("xback_l", 1211, 915, 1'b0);
    probe("xback_r", 1276, 915, 1'b0);
    frames(21);
    probe("ymax", 1128, 976, 1'b1);
    probe("ymax_u", 1128, 975, 1'b0);
    frames(1);
    probe("yback", 1124, 973, 1'b1);
    probe("yback_u", 1124, 972, 1'b0);

    set_en(1'b0);
    ticks = 0;
    probe("off0", 1124, 973, 1'b0);
    frames(5);
    chk("ticks_off", ticks, 5);
    probe("off5", 1124, 973, 1'b0);
    set_en(1'b1);
    probe("held", 1124, 973, 1'b1);
    frames(1);
    probe("moved", 1120, 970, 1'b1);
    probe("moved_r", 1184, 970, 1'b0);

    for (int i = 0; i < 600; i++) begin
      int h, v;
      if (i % 50 == 49) set_en(1'(($urandom_range(0, 3) != 0)));
      if (i % 7 == 3) frames($urandom_range(1, 40));
      if ($urandom_range(0, 1) == 1) begin
        h = HBP + mx + $urandom_range(0, 80) - 8;
        v = VBP + my + $urandom_range(0, 64) - 8;
      end else begin
        h = $urandom_range(0, 2047);
        v = $urandom_range(0, 2047);
      end
      if (h == 0 && v == 1059) v = 1060;
      step(h, v, 1'($urandom), 1'($urandom), 12'($urandom));
    end

    set_en(1'b1);
    frames(3);
    step(800, 500, 1'b0, 1'b0, BAR);
    clr_n = 1'b0;
    #1;
    chk("mid_hsync", dn.hsync, 1'b1);
    chk("mid_vsync", dn.vsync, 1'b1);
    chk("mid_rgb", {dn.red, dn.green, dn.blue}, 12'h000);
    chk("mid_tick", frame_tick, 1'b0);
    repeat (2) @(posedge dclk);
    #2;
    clr_n = 1'b1;
    model_reset();
    probe("rst_box", 0, 0, 1'b1);
    probe("rst_box_r", 64, 0, 1'b0);
    frames(1);
    probe("rst_move", 4, 3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
